// File: rtl/ntt_pkg.sv
// Shared NTT constants, coefficient width and controller state encoding.
package ntt_pkg;
    localparam int unsigned Q      = 8380417;
    localparam int unsigned N      = 256;
    localparam int unsigned LOGN   = 8;
    localparam int unsigned COEF_W = 24;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_RUN     = 2'd1;
    localparam state_t ST_BARRIER = 2'd2;
    localparam state_t ST_DONE    = 2'd3;
endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational butterfly operand address and twiddle index generator for one
// Cooley-Tukey layer: stage s selects the half-distance len = 128 >> s.
module ntt_addr_gen
    import ntt_pkg::*;
(
    input  logic [2:0] i_stage,
    input  logic [6:0] i_b,
    output logic [7:0] o_addr_a,
    output logic [7:0] o_addr_b,
    output logic [7:0] o_zeta_idx
);
    logic [7:0] w_b8;
    logic [7:0] w_len;
    logic [7:0] w_grp;

    assign w_b8  = {1'b0, i_b};
    assign w_len = 8'd128 >> i_stage;
    // Butterfly group index; selects both the block base and the twiddle.
    assign w_grp = w_b8 >> (3'd7 - i_stage);

    assign o_addr_a   = (w_grp << (4'd8 - {1'b0, i_stage})) | (w_b8 & (w_len - 8'd1));
    assign o_addr_b   = o_addr_a + w_len;
    assign o_zeta_idx = (8'd1 << i_stage) + w_grp;
endmodule

// File: rtl/ntt_ctrl.sv
// Forward-NTT sequencer: issues 8 x 128 butterflies with a bounded in-flight window,
// a per-layer writeback barrier and loader arbitration. Optional NTT_CTRL_STALL_CNT_EN.
module ntt_ctrl
    import ntt_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4,
    parameter int DW           = COEF_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          load_req,
    input  logic          load_we,
    input  logic [7:0]    load_addr,
    input  logic [DW-1:0] load_data,
    output logic          load_gnt,
    output logic          mem_we,
    output logic [7:0]    mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          bf_valid,
    input  logic          bf_ready,
    output logic [7:0]    bf_addr_a,
    output logic [7:0]    bf_addr_b,
    output logic [7:0]    zeta_idx,
    output logic [2:0]    stage,
    input  logic          wb_ack,
    output logic          busy,
    output logic          done,
    output logic          err
`ifdef NTT_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);
    localparam logic [3:0] LP_MAX = 4'(MAX_INFLIGHT);

    state_t     r_state;
    logic [2:0] r_stage;
    logic [6:0] r_b;
    logic [3:0] r_out;
    logic       r_err;

    logic       w_idle, w_run, w_bar;
    logic       w_start_ok, w_valid, w_fire, w_ack_ok;
    logic [3:0] w_out_nxt;
    logic [7:0] w_addr_a, w_addr_b, w_zeta;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_run      = (r_state == ST_RUN);
    assign w_bar      = (r_state == ST_BARRIER);
    assign w_start_ok = w_idle & start & ~load_req;
    assign w_valid    = w_run & (r_out < LP_MAX);
    assign w_fire     = w_valid & bf_ready;
    // An ack with nothing outstanding is a protocol error and must not underflow.
    assign w_ack_ok   = wb_ack & (r_out != 4'd0);
    assign w_out_nxt  = r_out + {3'b000, w_fire} - {3'b000, w_ack_ok};

    ntt_addr_gen u_addr_gen (
        .i_stage    (r_stage),
        .i_b        (r_b),
        .o_addr_a   (w_addr_a),
        .o_addr_b   (w_addr_b),
        .o_zeta_idx (w_zeta)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_stage <= 3'd0;
            r_b     <= 7'd0;
            r_out   <= 4'd0;
            r_err   <= 1'b0;
        end else begin
            r_out <= w_out_nxt;
            if (w_start_ok) begin
                r_err <= 1'b0;
            end else if (wb_ack && (r_out == 4'd0)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_state <= ST_RUN;
                        r_stage <= 3'd0;
                        r_b     <= 7'd0;
                    end
                end
                ST_RUN: begin
                    if (w_fire) begin
                        r_b <= r_b + 7'd1;
                        if (r_b == 7'd127) begin
                            r_state <= ST_BARRIER;
                        end
                    end
                end
                ST_BARRIER: begin
                    if (w_out_nxt == 4'd0) begin
                        if (r_stage == 3'd7) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_RUN;
                            r_stage <= r_stage + 3'd1;
                            r_b     <= 7'd0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_stage <= 3'd0;
                end
            endcase
        end
    end

    assign load_gnt  = w_idle & load_req;
    assign mem_we    = load_gnt & load_we;
    assign mem_addr  = load_gnt ? load_addr : 8'd0;
    assign mem_wdata = load_gnt ? load_data : '0;

    assign bf_valid  = w_valid;
    assign bf_addr_a = w_run ? w_addr_a : 8'd0;
    assign bf_addr_b = w_run ? w_addr_b : 8'd0;
    assign zeta_idx  = w_run ? w_zeta : 8'd0;
    assign stage     = r_stage;
    assign busy      = w_run | w_bar;
    assign done      = (r_state == ST_DONE);
    assign err       = r_err;

`ifdef NTT_CTRL_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_stall_cnt <= 16'd0;
        end else if (((w_valid & ~bf_ready) | w_bar) && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif
endmodule
